// File: rtl/pc_next_ctrl_pkg.sv
// Shared types and helpers for the PC next-value controller slice.
package pc_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HAZ    = 2'd1,
        IMWAIT = 2'd2
    } pc_ctrl_state_t;

    localparam int PC_W_DEF    = 16;
    localparam int PC_STEP_DEF = 4;

    // Clears the low log2(step) bits of an address; step must be a power of two.
    function automatic logic [31:0] align_pc(input logic [31:0] addr, input logic [31:0] step);
        return addr & ~(step - 32'd1);
    endfunction

endpackage

// File: rtl/pc_next_ctrl_if.sv
// Bundle of the PC-update, fetch-request and IF/ID control signals around pc_next_ctrl.
// The slave side is the controller; the master side is the pipeline around it.
interface pc_next_ctrl_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;
    logic            hazard_stall;
    logic            imem_ready;
    logic [PC_W-1:0] pc_new;
    logic            pc_write_zero;
    logic            imem_req;
    logic            ifid_flush;
    logic            ifid_hold;
    logic            misalign_err;

    modport master (
        output pc, redirect_valid, redirect_target, hazard_stall, imem_ready,
        input  pc_new, pc_write_zero, imem_req, ifid_flush, ifid_hold, misalign_err
    );

    modport slave (
        input  pc, redirect_valid, redirect_target, hazard_stall, imem_ready,
        output pc_new, pc_write_zero, imem_req, ifid_flush, ifid_hold, misalign_err
    );
endinterface

// File: rtl/pc_next_ctrl_timer.sv
// Small down-counter that times the remaining load-use hold cycles.
// Expired means the current cycle is the last one of the hold.
module pc_stall_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_loadVal,
    input  logic       i_clear,
    input  logic       i_dec,
    output logic       o_expired
);
    logic [3:0] r_count;

    // Count register: clear wins over load, load wins over decrement.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_expired = (r_count <= 4'd1);
endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC controller: sequential increment, branch/jump redirect, load-use hold
// and instruction-memory wait handling. Outputs are combinational so the PC
// register sees pc_new in the same cycle and captures it on the next edge.
module pc_next_ctrl
    import pc_pkg::*;
#(
    parameter int PC_W             = PC_W_DEF,
    parameter int PC_STEP          = PC_STEP_DEF,
    parameter int HAZ_STALL_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    pc_next_ctrl_if.slave  bus
);
    localparam logic [3:0] HAZ_LOAD  = 4'(HAZ_STALL_CYCLES - 1);
    localparam bit         HAZ_TIMED = (HAZ_STALL_CYCLES > 1);

    pc_ctrl_state_t  r_state;
    logic            r_pend;
    logic [PC_W-1:0] r_pendTgt;
    logic            r_pendMis;

    logic [PC_W-1:0] w_tgtAligned;
    logic            w_tgtMis;
    logic [PC_W-1:0] w_pcInc;
    logic            w_timerLoad;
    logic            w_timerClear;
    logic            w_timerDec;
    logic            w_timerExpired;

    logic [PC_W-1:0] w_pcNew;
    logic            w_pcWriteZero;
    logic            w_imemReq;
    logic            w_flush;
    logic            w_hold;
    logic            w_mis;

    assign w_tgtAligned = PC_W'(align_pc(32'(bus.redirect_target), 32'(PC_STEP)));
    assign w_tgtMis     = (w_tgtAligned != bus.redirect_target);
    assign w_pcInc      = bus.pc + PC_W'(PC_STEP);

    assign w_timerLoad  = (r_state == RUN) && !bus.redirect_valid && bus.hazard_stall && HAZ_TIMED;
    assign w_timerClear = (r_state == HAZ) && (bus.redirect_valid || w_timerExpired);
    assign w_timerDec   = (r_state == HAZ) && !w_timerClear;

    pc_stall_timer u_stallTimer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_timerLoad),
        .i_loadVal (HAZ_LOAD),
        .i_clear   (w_timerClear),
        .i_dec     (w_timerDec),
        .o_expired (w_timerExpired)
    );

    // State and pending-redirect registers; a redirect seen during a memory wait is parked until the word arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_pend    <= 1'b0;
            r_pendTgt <= '0;
            r_pendMis <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.redirect_valid) begin
                        r_state <= RUN;
                    end else if (bus.hazard_stall) begin
                        r_state <= HAZ_TIMED ? HAZ : RUN;
                    end else if (!bus.imem_ready) begin
                        r_state <= IMWAIT;
                    end
                end
                HAZ: begin
                    if (bus.redirect_valid || w_timerExpired) begin
                        r_state <= RUN;
                    end
                end
                IMWAIT: begin
                    if (bus.imem_ready) begin
                        r_state <= RUN;
                        r_pend  <= 1'b0;
                    end else if (bus.redirect_valid) begin
                        r_pend    <= 1'b1;
                        r_pendTgt <= w_tgtAligned;
                        r_pendMis <= w_tgtMis;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Output decode from registered state plus live inputs; reset forces every output low.
    always_comb begin
        w_pcNew       = '0;
        w_pcWriteZero = 1'b0;
        w_imemReq     = 1'b0;
        w_flush       = 1'b0;
        w_hold        = 1'b0;
        w_mis         = 1'b0;
        if (!reset) begin
            case (r_state)
                RUN: begin
                    w_imemReq = 1'b1;
                    if (bus.redirect_valid) begin
                        w_pcNew = w_tgtAligned;
                        w_flush = 1'b1;
                        w_mis   = w_tgtMis;
                    end else if (bus.hazard_stall) begin
                        w_pcNew       = bus.pc;
                        w_pcWriteZero = 1'b1;
                        w_hold        = 1'b1;
                        w_imemReq     = 1'b0;
                    end else if (!bus.imem_ready) begin
                        w_pcNew       = bus.pc;
                        w_pcWriteZero = 1'b1;
                    end else begin
                        w_pcNew = w_pcInc;
                    end
                end
                HAZ: begin
                    if (bus.redirect_valid) begin
                        w_pcNew = w_tgtAligned;
                        w_flush = 1'b1;
                        w_mis   = w_tgtMis;
                    end else begin
                        w_pcNew       = bus.pc;
                        w_pcWriteZero = 1'b1;
                        w_hold        = 1'b1;
                    end
                end
                IMWAIT: begin
                    w_imemReq = 1'b1;
                    if (!bus.imem_ready) begin
                        w_pcNew       = bus.pc;
                        w_pcWriteZero = 1'b1;
                    end else if (bus.redirect_valid) begin
                        w_pcNew = w_tgtAligned;
                        w_flush = 1'b1;
                        w_mis   = w_tgtMis;
                    end else if (r_pend) begin
                        w_pcNew = r_pendTgt;
                        w_flush = 1'b1;
                        w_mis   = r_pendMis;
                    end else begin
                        w_pcNew = w_pcInc;
                    end
                end
                default: begin
                    w_pcNew = '0;
                end
            endcase
        end
    end

    assign bus.pc_new        = w_pcNew;
    assign bus.pc_write_zero = w_pcWriteZero;
    assign bus.imem_req      = w_imemReq;
    assign bus.ifid_flush    = w_flush;
    assign bus.ifid_hold     = w_hold;
    assign bus.misalign_err  = w_mis;
endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl: each driven cycle queues its hand-computed
// expected outputs, and an independent monitor compares them at the falling edge.
module tb_pc_next_ctrl;
    logic clk;
    logic reset;

    pc_next_ctrl_if #(.PC_W(16)) bus ();

    pc_next_ctrl #(
        .PC_W             (16),
        .PC_STEP          (4),
        .HAZ_STALL_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Flag order: {pc_write_zero, imem_req, ifid_flush, ifid_hold, misalign_err}
    logic [15:0] expPcQ[$];
    logic        expChkPcQ[$];
    logic [4:0]  expFlagQ[$];
    logic [4:0]  expMaskQ[$];
    string       expNameQ[$];

    int testsRun = 0;
    int testsFailed = 0;
    bit stimDone = 1'b0;

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] NOREQ = 5'b10111;

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(
        input logic        rst,
        input logic [15:0] pc,
        input logic        rv,
        input logic [15:0] rt,
        input logic        hz,
        input logic        rdy,
        input logic [15:0] ePc,
        input logic        chkPc,
        input logic [4:0]  eFlags,
        input logic [4:0]  eMask,
        input string       name
    );
        @(posedge clk);
        #1;
        reset               = rst;
        bus.pc              = pc;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.hazard_stall    = hz;
        bus.imem_ready      = rdy;
        expPcQ.push_back(ePc);
        expChkPcQ.push_back(chkPc);
        expFlagQ.push_back(eFlags);
        expMaskQ.push_back(eMask);
        expNameQ.push_back(name);
    endtask

    task automatic checkOutput();
        logic [15:0] ePc;
        logic        chkPc;
        logic [4:0]  eFlags;
        logic [4:0]  eMask;
        logic [4:0]  aFlags;
        string       name;
        ePc    = expPcQ.pop_front();
        chkPc  = expChkPcQ.pop_front();
        eFlags = expFlagQ.pop_front();
        eMask  = expMaskQ.pop_front();
        name   = expNameQ.pop_front();
        aFlags = {bus.pc_write_zero, bus.imem_req, bus.ifid_flush, bus.ifid_hold, bus.misalign_err};
        testsRun++;
        if (((aFlags ^ eFlags) & eMask) != 5'b0 || (chkPc && (bus.pc_new !== ePc))) begin
            testsFailed++;
            $display("[TB] FAIL %s: got pc_new=%h flags(pwz,req,flush,hold,mis)=%b, expected pc_new=%h flags=%b mask=%b",
                     name, bus.pc_new, aFlags, ePc, eFlags, eMask);
        end
        testsRun++;
        if (bus.ifid_flush && bus.ifid_hold) begin
            testsFailed++;
            $display("[TB] FAIL %s/flush_hold_exclusive: got flush=1 hold=1, expected not both", name);
        end
    endtask

    // Monitor: pops one expected record per cycle the stimulus drove and compares it mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (expPcQ.size() > 0) checkOutput();
        end
    end

    // Directed stimulus: PC sequence, wrap, hazard hold, memory wait with redirect, HAZ abort, reset mid-wait.
    initial begin
        reset = 1'b1;
        bus.pc = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus.hazard_stall = 1'b0;
        bus.imem_ready = 1'b0;

        applyStimulus(1, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 1, 5'b00000, ALL, "reset_idle");
        applyStimulus(1, 16'h1234, 1, 16'h0102, 1, 0, 16'h0000, 1, 5'b00000, ALL, "reset_busy_inputs");

        applyStimulus(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 1, 5'b01000, ALL, "seq_0");
        applyStimulus(0, 16'h0004, 0, 16'h0000, 0, 1, 16'h0008, 1, 5'b01000, ALL, "seq_4");
        applyStimulus(0, 16'h0008, 0, 16'h0000, 0, 1, 16'h000C, 1, 5'b01000, ALL, "seq_8");
        applyStimulus(0, 16'hFFFC, 0, 16'h0000, 0, 1, 16'h0000, 1, 5'b01000, ALL, "wrap_fffc");

        applyStimulus(0, 16'h0010, 0, 16'h0000, 1, 1, 16'h0000, 0, 5'b10010, ALL, "haz_c1");
        applyStimulus(0, 16'h0010, 0, 16'h0000, 0, 1, 16'h0000, 0, 5'b10010, ALL, "haz_c2");
        applyStimulus(0, 16'h0010, 0, 16'h0000, 1, 1, 16'h0000, 0, 5'b10010, ALL, "haz_c3_no_extend");
        applyStimulus(0, 16'h0010, 0, 16'h0000, 0, 1, 16'h0014, 1, 5'b01000, ALL, "haz_resume");

        applyStimulus(0, 16'h0020, 0, 16'h0000, 0, 0, 16'h0000, 0, 5'b11000, ALL, "imw_c1");
        applyStimulus(0, 16'h0020, 1, 16'h0102, 0, 0, 16'h0000, 0, 5'b11000, ALL, "imw_c2_redirect");
        applyStimulus(0, 16'h0020, 0, 16'h0000, 1, 0, 16'h0000, 0, 5'b11000, ALL, "imw_c3_haz_ignored");
        applyStimulus(0, 16'h0020, 0, 16'h0000, 0, 0, 16'h0000, 0, 5'b11000, ALL, "imw_c4");
        applyStimulus(0, 16'h0020, 0, 16'h0000, 0, 1, 16'h0100, 1, 5'b01101, ALL, "imw_ready_pend");
        applyStimulus(0, 16'h0100, 0, 16'h0000, 0, 1, 16'h0104, 1, 5'b01000, ALL, "imw_after_pend");

        applyStimulus(0, 16'h0030, 0, 16'h0000, 1, 1, 16'h0000, 0, 5'b10010, ALL, "habort_hazard");
        applyStimulus(0, 16'h0030, 1, 16'h0040, 0, 1, 16'h0040, 1, 5'b00100, NOREQ, "habort_redirect");
        applyStimulus(0, 16'h0040, 0, 16'h0000, 0, 1, 16'h0044, 1, 5'b01000, ALL, "habort_run");

        applyStimulus(0, 16'h0044, 1, 16'h0080, 1, 0, 16'h0080, 1, 5'b01100, ALL, "prio_redirect");
        applyStimulus(0, 16'h0080, 0, 16'h0000, 0, 1, 16'h0084, 1, 5'b01000, ALL, "prio_after");

        applyStimulus(0, 16'h0060, 0, 16'h0000, 0, 0, 16'h0000, 0, 5'b11000, ALL, "ovr_wait");
        applyStimulus(0, 16'h0060, 1, 16'h0300, 0, 0, 16'h0000, 0, 5'b11000, ALL, "ovr_pend1");
        applyStimulus(0, 16'h0060, 1, 16'h0304, 0, 0, 16'h0000, 0, 5'b11000, ALL, "ovr_pend2");
        applyStimulus(0, 16'h0060, 1, 16'h0402, 0, 1, 16'h0400, 1, 5'b01101, ALL, "ovr_new_wins");
        applyStimulus(0, 16'h0400, 0, 16'h0000, 0, 1, 16'h0404, 1, 5'b01000, ALL, "ovr_after");

        applyStimulus(0, 16'h0070, 0, 16'h0000, 0, 0, 16'h0000, 0, 5'b11000, ALL, "ovr2_wait");
        applyStimulus(0, 16'h0070, 1, 16'h0500, 0, 0, 16'h0000, 0, 5'b11000, ALL, "ovr2_pend1");
        applyStimulus(0, 16'h0070, 1, 16'h0508, 0, 0, 16'h0000, 0, 5'b11000, ALL, "ovr2_pend2");
        applyStimulus(0, 16'h0070, 0, 16'h0000, 0, 1, 16'h0508, 1, 5'b01100, ALL, "ovr2_latest_pend");

        applyStimulus(0, 16'h0050, 0, 16'h0000, 0, 0, 16'h0000, 0, 5'b11000, ALL, "rst_wait");
        applyStimulus(0, 16'h0050, 1, 16'h0200, 0, 0, 16'h0000, 0, 5'b11000, ALL, "rst_pend");
        applyStimulus(1, 16'h0050, 0, 16'h0000, 0, 0, 16'h0000, 1, 5'b00000, ALL, "rst_assert");
        applyStimulus(1, 16'h0050, 0, 16'h0000, 0, 1, 16'h0000, 1, 5'b00000, ALL, "rst_held");
        applyStimulus(0, 16'h0050, 0, 16'h0000, 0, 1, 16'h0054, 1, 5'b01000, ALL, "rst_resume");
        applyStimulus(0, 16'h0054, 0, 16'h0000, 0, 1, 16'h0058, 1, 5'b01000, ALL, "rst_resume2");

        stimDone = 1'b1;
    end

    // End of run: drain the scoreboard within a bounded number of cycles, then summarise.
    initial begin
        int guard;
        guard = 0;
        while (!stimDone && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        repeat (20) begin
            if (expPcQ.size() == 0) break;
            @(posedge clk);
        end
        testsRun++;
        if (!stimDone || expPcQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got stimDone=%0d pending=%0d, expected stimDone=1 pending=0",
                     stimDone, expPcQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
